// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD pairing-engine stimulus driver.
//   - FSM state encoding, error codes, beat counts
//   - LFSR tap mask, zero-seed substitute and one-step LFSR helper
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    RECV,
    CHECK,
    REPORT
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_PROTO    = 2'd3;

  localparam int unsigned N_IN_BEATS  = 6;
  localparam int unsigned N_OUT_BEATS = 4;
  localparam int unsigned OPND_W      = 4;
  localparam int unsigned SUM_W       = 5;
  localparam int unsigned LFSR_W      = 8;

  // Feedback taps at bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 8'hB8;
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 8'hA5;

  // Fibonacci shift-left step: new bit0 is the XOR of the tapped bits
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gcd_sub_iter.sv
// Subtraction-based Euclid on 5-bit operands, one subtract per cycle.
//   start  : load a/b and begin (restarts any run in progress)
//   busy   : iteration in progress
//   done   : one-cycle pulse, result valid from then on
//   result : gcd(a,b); gcd(x,0)=gcd(0,x)=x
module gcd_sub_iter
  import gcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUM_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] result
);

  logic [SUM_W-1:0] x_q, x_d, y_q, y_d, result_q, result_d;
  logic             busy_q, busy_d, done_q, done_d;

  // Iteration step
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    busy_d   = busy_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (start) begin
      x_d    = a;
      y_d    = b;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if ((y_q == '0) || (x_q == y_q)) begin
        result_d = x_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
      end else if (x_q == '0) begin
        result_d = y_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
      end else if (x_q > y_q) begin
        x_d = x_q - y_q;
      end else begin
        y_d = y_q - x_q;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: rtl/gcd_stim_driver.sv
// Stimulus driver and response checker for the GCD pairing engine.
//   start/seed          : launch a transaction (IDLE only); seed 0 -> 8'hA5
//   in_valid/in_data    : six legalised LFSR nibbles, back to back
//   out_valid/out_data  : four response beats (three pair sums, then GCD)
//   busy/done/pass/err_code : status; pass/err_code held until next done
module gcd_stim_driver
  import gcd_pkg::*;
#(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  output logic              in_valid,
  output logic [OPND_W-1:0] in_data,
  input  logic              out_valid,
  input  logic [SUM_W-1:0]  out_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        err_code
);

  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned BEAT_W = $clog2(N_IN_BEATS + 1);
  localparam int unsigned RX_W   = $clog2(N_OUT_BEATS);

  state_t                             state_q, state_d;
  logic [BEAT_W-1:0]                  beat_cnt_q, beat_cnt_d;
  logic [RX_W-1:0]                    rx_cnt_q, rx_cnt_d;
  logic [TMR_W-1:0]                   timer_q, timer_d;
  logic [LFSR_W-1:0]                  lfsr_q, lfsr_d;
  logic                               odd_par_q, odd_par_d;
  logic                               odd_v_q, odd_v_d, even_v_q, even_v_d;
  logic [OPND_W-1:0]                  odd_q, odd_d, even_q, even_d;
  logic [2:0][SUM_W-1:0]              sum_q, sum_d;
  logic [1:0]                         sum_cnt_q, sum_cnt_d;
  logic [N_OUT_BEATS-1:0][SUM_W-1:0]  rx_q, rx_d;
  logic [1:0]                         err_q, err_d;
  logic                               gcd_phase_q, gcd_phase_d;
  logic                               gcd_ok_q, gcd_ok_d;
  logic [SUM_W-1:0]                   gcd_val_q, gcd_val_d;
  logic                               in_valid_q, in_valid_d, busy_q, busy_d;
  logic                               done_q, done_d, pass_q, pass_d;
  logic [OPND_W-1:0]                  in_data_q, in_data_d;
  logic [1:0]                         err_code_q, err_code_d;

  logic [LFSR_W-1:0] lfsr_src_c, lfsr_nx_c;
  logic [OPND_W-1:0] nib_c;
  logic              issue_c, mismatch_c;
  logic              g_start_c, g_busy, g_done;
  logic [SUM_W-1:0]  g_a_c, g_b_c, g_result;

  gcd_sub_iter u_gcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (g_start_c),
    .a      (g_a_c),
    .b      (g_b_c),
    .busy   (g_busy),
    .done   (g_done),
    .result (g_result)
  );

  // Next operand: advance LFSR (from the seed when launching), then legalise
  always_comb begin
    lfsr_src_c = lfsr_q;
    if (state_q == IDLE) lfsr_src_c = (seed == '0) ? ZERO_SEED_SUB : seed;
    lfsr_nx_c = lfsr_step(lfsr_src_c);
    nib_c     = lfsr_nx_c[OPND_W-1:0];
    if (nib_c == '0) nib_c = OPND_W'(2);
    // Last beat: bit0 equals the running odd parity so the odd count ends even
    if (beat_cnt_q == BEAT_W'(N_IN_BEATS - 1)) nib_c[0] = odd_par_q;
  end

  assign mismatch_c = (rx_q[0] != sum_q[0]) || (rx_q[1] != sum_q[1]) ||
                      (rx_q[2] != sum_q[2]) || (rx_q[3] != gcd_val_q);

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    timer_d     = timer_q;
    lfsr_d      = lfsr_q;
    odd_par_d   = odd_par_q;
    odd_v_d     = odd_v_q;
    odd_d       = odd_q;
    even_v_d    = even_v_q;
    even_d      = even_q;
    sum_d       = sum_q;
    sum_cnt_d   = sum_cnt_q;
    rx_d        = rx_q;
    err_d       = err_q;
    gcd_phase_d = gcd_phase_q;
    gcd_ok_d    = gcd_ok_q;
    gcd_val_d   = gcd_val_q;
    in_valid_d  = 1'b0;
    in_data_d   = '0;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_code_d  = err_code_q;
    issue_c     = 1'b0;
    g_start_c   = 1'b0;
    g_a_c       = g_result;
    g_b_c       = sum_q[2];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SEND;
          issue_c    = 1'b1;
          beat_cnt_d = BEAT_W'(1);
          err_d      = ERR_OK;
        end
      end
      SEND: begin
        if (out_valid) err_d = ERR_PROTO;
        if (beat_cnt_q == BEAT_W'(N_IN_BEATS)) begin
          if (out_valid || (err_q == ERR_PROTO)) begin
            state_d = REPORT;
          end else begin
            state_d = WAIT;
            timer_d = TMR_W'(1);
          end
        end else begin
          issue_c    = 1'b1;
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
        end
      end
      WAIT: begin
        // Timer counts cycles since the last beat; REPORT and the registered
        // done add the final two, so done lands TIMEOUT cycles after it
        if (out_valid) begin
          rx_d[0]  = out_data;
          rx_cnt_d = RX_W'(1);
          state_d  = RECV;
        end else if (timer_q >= TMR_W'(TIMEOUT - 2)) begin
          err_d   = ERR_TIMEOUT;
          state_d = REPORT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RECV: begin
        if (out_valid) begin
          rx_d[rx_cnt_q] = out_data;
          if (rx_cnt_q == RX_W'(N_OUT_BEATS - 1)) state_d = CHECK;
          else rx_cnt_d = rx_cnt_q + RX_W'(1);
        end else begin
          err_d   = ERR_PROTO;
          state_d = REPORT;
        end
      end
      CHECK: begin
        if (gcd_ok_q && !g_busy) begin
          if (mismatch_c) err_d = ERR_MISMATCH;
          state_d = REPORT;
        end
      end
      REPORT: begin
        done_d     = 1'b1;
        pass_d     = (err_q == ERR_OK);
        err_code_d = err_q;
        state_d    = IDLE;
        beat_cnt_d = '0;
        rx_cnt_d   = '0;
        odd_par_d  = 1'b0;
        odd_v_d    = 1'b0;
        even_v_d   = 1'b0;
        sum_cnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase

    // Drive a beat and mirror the engine's odd/even pairing
    if (issue_c) begin
      in_valid_d = 1'b1;
      in_data_d  = nib_c;
      lfsr_d     = lfsr_nx_c;
      odd_par_d  = odd_par_q ^ nib_c[0];
      if (nib_c[0]) begin
        if (odd_v_q) begin
          sum_d[sum_cnt_q] = SUM_W'(odd_q) + SUM_W'(nib_c);
          sum_cnt_d        = sum_cnt_q + 2'd1;
          odd_v_d          = 1'b0;
        end else begin
          odd_d   = nib_c;
          odd_v_d = 1'b1;
        end
      end else begin
        if (even_v_q) begin
          sum_d[sum_cnt_q] = SUM_W'(even_q) + SUM_W'(nib_c);
          sum_cnt_d        = sum_cnt_q + 2'd1;
          even_v_d         = 1'b0;
        end else begin
          even_d   = nib_c;
          even_v_d = 1'b1;
        end
      end
    end

    // Expected GCD: gcd(s0,s1) launched on entry to WAIT, then gcd(r,s2)
    if ((state_q == SEND) && (state_d == WAIT)) begin
      g_start_c   = 1'b1;
      g_a_c       = sum_q[0];
      g_b_c       = sum_q[1];
      gcd_phase_d = 1'b0;
      gcd_ok_d    = 1'b0;
    end else if (g_done && (state_q inside {WAIT, RECV, CHECK})) begin
      if (!gcd_phase_q) begin
        g_start_c   = 1'b1;
        gcd_phase_d = 1'b1;
      end else begin
        gcd_ok_d  = 1'b1;
        gcd_val_d = g_result;
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      rx_cnt_q    <= '0;
      timer_q     <= '0;
      lfsr_q      <= ZERO_SEED_SUB;
      odd_par_q   <= 1'b0;
      odd_v_q     <= 1'b0;
      odd_q       <= '0;
      even_v_q    <= 1'b0;
      even_q      <= '0;
      sum_q       <= '0;
      sum_cnt_q   <= '0;
      rx_q        <= '0;
      err_q       <= ERR_OK;
      gcd_phase_q <= 1'b0;
      gcd_ok_q    <= 1'b0;
      gcd_val_q   <= '0;
      in_valid_q  <= 1'b0;
      in_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_code_q  <= ERR_OK;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      timer_q     <= timer_d;
      lfsr_q      <= lfsr_d;
      odd_par_q   <= odd_par_d;
      odd_v_q     <= odd_v_d;
      odd_q       <= odd_d;
      even_v_q    <= even_v_d;
      even_q      <= even_d;
      sum_q       <= sum_d;
      sum_cnt_q   <= sum_cnt_d;
      rx_q        <= rx_d;
      err_q       <= err_d;
      gcd_phase_q <= gcd_phase_d;
      gcd_ok_q    <= gcd_ok_d;
      gcd_val_q   <= gcd_val_d;
      in_valid_q  <= in_valid_d;
      in_data_q   <= in_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_code_q  <= err_code_d;
    end
  end

  assign in_valid = in_valid_q;
  assign in_data  = in_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_gcd_stim_driver.sv
// Testbench for gcd_stim_driver: table of seeded transactions against a
// scripted engine, plus reset, timeout and gcd_sub_iter sequences.
module tb_gcd_stim_driver;

  localparam int unsigned TMO = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_valid = 1'b0;
  logic [4:0] out_data = 5'd0;
  logic       busy, done, pass;
  logic [1:0] err_code;

  logic       g_start = 1'b0;
  logic [4:0] g_a = 5'd0, g_b = 5'd0;
  logic       g_busy, g_done;
  logic [4:0] g_res;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gcd_stim_driver #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .seed     (seed),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_code (err_code)
  );

  gcd_sub_iter u_unit (
    .clk   (clk),
    .rst_n (rst_n),
    .start (g_start),
    .a     (g_a),
    .b     (g_b),
    .busy  (g_busy),
    .done  (g_done),
    .result(g_res)
  );

  typedef struct packed {
    logic [7:0]      seed;
    logic [2:0]      n_resp;
    logic [3:0][4:0] resp;
    logic [5:0][3:0] exp_in;
    logic            exp_pass;
    logic [1:0]      exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] sd, input int n,
                              input int r0, input int r1, input int r2, input int r3,
                              input int d0, input int d1, input int d2,
                              input int d3, input int d4, input int d5,
                              input int ep, input int ee);
    vec_t v;
    v.seed      = sd;
    v.n_resp    = 3'(n);
    v.resp[0]   = 5'(r0);
    v.resp[1]   = 5'(r1);
    v.resp[2]   = 5'(r2);
    v.resp[3]   = 5'(r3);
    v.exp_in[0] = 4'(d0);
    v.exp_in[1] = 4'(d1);
    v.exp_in[2] = 4'(d2);
    v.exp_in[3] = 4'(d3);
    v.exp_in[4] = 4'(d4);
    v.exp_in[5] = 4'(d5);
    v.exp_pass  = 1'(ep);
    v.exp_err   = 2'(ee);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    chk({name, "_done_seen"}, int'(done), 1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("v%0d", idx);
    seed  = v.seed;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s_in_valid_b%0d", nm, i), int'(in_valid), 1);
      chk($sformatf("%s_in_data_b%0d", nm, i), int'(in_data), int'(v.exp_in[i]));
      tick();
    end
    chk({nm, "_in_valid_low"}, int'(in_valid), 0);
    chk({nm, "_in_data_zero"}, int'(in_data), 0);
    for (int k = 0; k < int'(v.n_resp); k++) begin
      out_valid = 1'b1;
      out_data  = v.resp[k];
      tick();
    end
    out_valid = 1'b0;
    out_data  = 5'd0;
    wait_done(nm);
    chk({nm, "_pass"}, int'(pass), int'(v.exp_pass));
    chk({nm, "_err_code"}, int'(err_code), int'(v.exp_err));
    chk({nm, "_busy_at_done"}, int'(busy), 0);
    tick();
    chk({nm, "_done_one_cycle"}, int'(done), 0);
  endtask

  // Seed 01 -> 2,4,8,1,3,6 (sums 6,4,14, gcd 2)
  // Seed A5 (and 00) -> 10,5,10,4,9,2 (sums 20,14,6, gcd 2)
  vec_t vecs[9];

  initial begin
    int  cnt;
    bit  flag;

    vecs[0] = mk(8'h01, 4,  6,  4, 14, 2,   2, 4, 8, 1, 3, 6,  1, 0);
    vecs[1] = mk(8'h01, 4,  6,  4, 14, 3,   2, 4, 8, 1, 3, 6,  0, 1);
    vecs[2] = mk(8'h01, 4,  6,  5, 14, 2,   2, 4, 8, 1, 3, 6,  0, 1);
    vecs[3] = mk(8'h01, 2,  6,  4,  0, 0,   2, 4, 8, 1, 3, 6,  0, 3);
    vecs[4] = mk(8'h00, 2, 20, 14,  0, 0,  10, 5,10, 4, 9, 2,  0, 3);
    vecs[5] = mk(8'hA5, 2, 20, 14,  0, 0,  10, 5,10, 4, 9, 2,  0, 3);
    vecs[6] = mk(8'h01, 0,  0,  0,  0, 0,   2, 4, 8, 1, 3, 6,  0, 2);
    vecs[7] = mk(8'hA5, 4, 20, 14,  6, 2,  10, 5,10, 4, 9, 2,  1, 0);
    vecs[8] = mk(8'h00, 4, 20, 14,  6, 2,  10, 5,10, 4, 9, 2,  1, 0);

    // Power-on reset
    #2 rst_n = 1'b0;
    #2;
    chk("reset_outputs", int'({in_valid, in_data, busy, done, pass, err_code}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy || in_valid) flag = 1'b1;
    end
    chk("idle_after_reset", int'(flag), 0);

    for (int v = 0; v < 9; v++) run_vec(vecs[v], v);

    // pass/err_code held after a passing transaction, then cleared by reset
    repeat (5) tick();
    chk("pass_held", int'(pass), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midcycle_reset_outputs", int'({in_valid, in_data, busy, done, pass, err_code}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy) flag = 1'b1;
    end
    chk("busy_low_until_start", int'(flag), 0);

    // Timeout latency measured from the last beat; a start during busy is ignored
    seed  = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("tmo_last_beat", int'(in_data), 6);
    cnt = 0;
    while (!done && cnt < 200) begin
      tick();
      cnt++;
      start = 1'b0;
      if (cnt == 3) start = 1'b1;
    end
    start = 1'b0;
    chk("tmo_latency", cnt, int'(TMO));
    chk("tmo_err_code", int'(err_code), 2);
    chk("tmo_pass", int'(pass), 0);
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (in_valid || busy) flag = 1'b1;
    end
    chk("start_during_busy_ignored", int'(flag), 0);

    // Reset during the fourth beat aborts without done
    seed  = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("abort_beat3_data", int'(in_data), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_valid", int'(in_valid), 0);
    chk("abort_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done || in_valid) flag = 1'b1;
    end
    chk("abort_no_done", int'(flag), 0);
    run_vec(vecs[0], 90);

    // gcd_sub_iter unit checks
    for (int t = 0; t < 3; t++) begin
      int a, b, r;
      case (t)
        0:       begin a = 12; b = 18; r = 6; end
        1:       begin a = 30; b = 1;  r = 1; end
        default: begin a = 7;  b = 0;  r = 7; end
      endcase
      g_a     = 5'(a);
      g_b     = 5'(b);
      g_start = 1'b1;
      tick();
      g_start = 1'b0;
      chk($sformatf("unit%0d_busy", t), int'(g_busy), 1);
      cnt = 0;
      while (!g_done && cnt < 100) begin
        tick();
        cnt++;
      end
      chk($sformatf("unit%0d_done", t), int'(g_done), 1);
      chk($sformatf("unit%0d_result", t), int'(g_res), r);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
